// File: rtl/register_write_stage.sv
// Eight-entry register bank feeding the read multiplexer: byte-enabled writes,
// a sequenced clear-all sweep, a per-register dirty bitmap and ack/err pulses.
module register_write_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wAddr,
    input  logic [DATA_WIDTH-1:0]   wData,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    clr,
    output logic                    busy,
    output logic                    wr_ack,
    output logic                    wr_err,
    output logic [7:0]              dirty,
    output logic [DATA_WIDTH-1:0]   to_reg0,
    output logic [DATA_WIDTH-1:0]   to_reg1,
    output logic [DATA_WIDTH-1:0]   to_reg2,
    output logic [DATA_WIDTH-1:0]   to_reg3,
    output logic [DATA_WIDTH-1:0]   to_reg4,
    output logic [DATA_WIDTH-1:0]   to_reg5,
    output logic [DATA_WIDTH-1:0]   to_reg6,
    output logic [DATA_WIDTH-1:0]   to_reg7
);

    localparam int NUM_REGS  = 8;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;
    logic                    wr_accept;
    logic                    wr_drop;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // clr wins over a simultaneous write; any write outside plain IDLE is dropped.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wr_accept = 1'b0;
        wr_drop   = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                    wr_drop   = we;
                end else begin
                    wr_accept = we;
                end
            end
            CLEAR: begin
                wr_drop = we;
                ptr_nxt = ptr + ADDR_WIDTH'(1);
                if (ptr == ADDR_WIDTH'(NUM_REGS - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            dirty  <= '0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_accept;
            wr_err <= wr_drop;
            if (state == CLEAR) begin
                regs[ptr]  <= '0;
                dirty[ptr] <= 1'b0;
            end else if (wr_accept) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (be[b]) begin
                        regs[wAddr][b*8 +: 8] <= wData[b*8 +: 8];
                    end
                end
                if (|be) begin
                    dirty[wAddr] <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state == CLEAR);
    assign to_reg0 = regs[0];
    assign to_reg1 = regs[1];
    assign to_reg2 = regs[2];
    assign to_reg3 = regs[3];
    assign to_reg4 = regs[4];
    assign to_reg5 = regs[5];
    assign to_reg6 = regs[6];
    assign to_reg7 = regs[7];

endmodule

// File: tb/tb_register_write_stage.sv
// Randomized and directed bench for register_write_stage against a
// behavioural model of the register bank and clear sweep.
module tb_register_write_stage;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [3:0]  be;
    logic        clr;
    logic        busy;
    logic        wr_ack;
    logic        wr_err;
    logic [7:0]  dirty;
    logic [31:0] rd [8];

    register_write_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wAddr   (wAddr),
        .wData   (wData),
        .be      (be),
        .clr     (clr),
        .busy    (busy),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .dirty   (dirty),
        .to_reg0 (rd[0]),
        .to_reg1 (rd[1]),
        .to_reg2 (rd[2]),
        .to_reg3 (rd[3]),
        .to_reg4 (rd[4]),
        .to_reg5 (rd[5]),
        .to_reg6 (rd[6]),
        .to_reg7 (rd[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;

    // model: register contents, dirty set, and how many sweep edges remain
    logic [31:0] m_reg [8];
    logic [7:0]  m_dirty;
    int          m_left;
    logic        m_ack;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_dirty = '0;
        m_left  = 0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        m_ack = 1'b0;
        m_err = 1'b0;
        if (m_left > 0) begin
            m_reg[8 - m_left]   = '0;
            m_dirty[8 - m_left] = 1'b0;
            m_left--;
            if (we) m_err = 1'b1;
        end else if (clr) begin
            m_left = 8;
            if (we) m_err = 1'b1;
        end else if (we) begin
            m_ack = 1'b1;
            for (int b = 0; b < 4; b++)
                if (be[b]) m_reg[wAddr][b*8 +: 8] = wData[b*8 +: 8];
            if (be != 4'h0) m_dirty[wAddr] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 8; i++) chk($sformatf("to_reg%0d", i), rd[i], m_reg[i]);
        chk("dirty", {24'h0, dirty}, {24'h0, m_dirty});
        chk("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
        chk("wr_ack", {31'h0, wr_ack}, {31'h0, m_ack});
        chk("wr_err", {31'h0, wr_err}, {31'h0, m_err});
        chk("ack_err_excl", {31'h0, wr_ack & wr_err}, 32'h0);
    endtask

    task automatic step(input logic w, input logic c, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        we = w; clr = c; wAddr = a; wData = d; be = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (wr_ack) ack_cnt++;
        @(negedge clk);
        we = 1'b0; clr = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    logic [31:0] init_vals [8];

    initial begin
        init_vals[0] = 32'h0000000f; init_vals[1] = 32'h000000ff;
        init_vals[2] = 32'h00000fff; init_vals[3] = 32'h0000ffff;
        init_vals[4] = 32'h000f0000; init_vals[5] = 32'h00ff0000;
        init_vals[6] = 32'h0fff0000; init_vals[7] = 32'hffff0000;
        we = 0; clr = 0; wAddr = 0; wData = 0; be = 0;
        reset_n = 1'b1;
        model_reset();
        #2 reset_n = 1'b0;
        #1 check_all();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // per-address writes
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'(i), init_vals[i], 4'hf);
        chk("ack_count", ack_cnt, 8);
        chk("dirty_all", {24'h0, dirty}, 32'h000000ff);
        idle();

        // byte enables
        step(1'b1, 1'b0, 3'd3, 32'hAABBCCDD, 4'b1010);
        chk("be_merge", rd[3], 32'hAA00CCFF);
        step(1'b1, 1'b0, 3'd2, 32'h12345678, 4'b0000);
        chk("be_zero_val", rd[2], 32'h00000fff);

        // clear sweep
        step(1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
        chk("sweep_start_busy", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk("sweep_busy_pre", {31'h0, busy}, 32'h1);
            idle();
            chk($sformatf("sweep_zero%0d", k), rd[k], 32'h0);
        end
        chk("sweep_done_busy", {31'h0, busy}, 32'h0);
        chk("sweep_done_dirty", {24'h0, dirty}, 32'h0);

        // write during sweep
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'(i), init_vals[i] | 32'h1, 4'hf);
        step(1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
        idle(); idle();
        step(1'b1, 1'b0, 3'd5, 32'hDEADBEEF, 4'hf);
        chk("sweep_wr_err", {31'h0, wr_err}, 32'h1);
        for (int k = 0; k < 5; k++) idle();
        chk("sweep_reg5", rd[5], 32'h0);

        // simultaneous we and clr in IDLE, then post-sweep write to 7
        step(1'b1, 1'b0, 3'd1, 32'h11111111, 4'hf);
        step(1'b1, 1'b1, 3'd1, 32'h22222222, 4'hf);
        chk("simul_err", {31'h0, wr_err}, 32'h1);
        chk("simul_busy", {31'h0, busy}, 32'h1);
        chk("simul_nowrite", rd[1], 32'h11111111);
        for (int k = 0; k < 8; k++) idle();
        step(1'b1, 1'b0, 3'd7, 32'hCAFEF00D, 4'hf);
        chk("post_ack", {31'h0, wr_ack}, 32'h1);
        chk("post_dirty", {24'h0, dirty}, 32'h00000080);

        // async reset mid-sweep
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'(i), $urandom | 32'h1, 4'hf);
        step(1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) idle();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset_n = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 3'd4, 32'h5A5A5A5A, 4'hf);
        chk("after_rst_ack", {31'h0, wr_ack}, 32'h1);

        // clr held high: back-to-back sweeps
        for (int k = 0; k < 20; k++) step(1'(k % 2), 1'b1, 3'(k), $urandom, 4'hf);
        for (int k = 0; k < 9; k++) idle();

        // randomized traffic
        for (int k = 0; k < 500; k++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3),
                 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/register_write_stage.md
Name: register_write_stage

Overview:
- Upstream stage of the register file read path: holds the eight 32-bit registers whose outputs drive the read multiplexer's from_reg0..from_reg7 inputs.
- Accepts single-cycle write requests with byte enables.
- Provides a sequenced clear-all sweep, a per-register dirty bitmap, and write acknowledge/error pulses.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 3, register address width; NUM_REGS = 8 is fixed by the eight output ports.

Ports:
- clk  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- we  input  1  write request, sampled on rising edge of clk.
- wAddr  input  ADDR_WIDTH  target register index.
- wData  input  DATA_WIDTH  write data.
- be  input  DATA_WIDTH/8  byte enables; be[i] covers wData[8i+7:8i].
- clr  input  1  start clear-all sweep (level sampled in IDLE).
- busy  output  1  high while the clear sweep is running.
- wr_ack  output  1  one-cycle pulse for an accepted write.
- wr_err  output  1  one-cycle pulse for a dropped write.
- dirty  output  8  bit n set when to_regn has been written since the last reset or clear.
- to_reg0..to_reg7  output  DATA_WIDTH each  register contents, fed to from_reg0..from_reg7 of the read stage.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately, including mid-sweep):
  - to_reg0..7 = 0, dirty = 8'h00, busy = 0, wr_ack = 0, wr_err = 0.
  - State = IDLE, clear pointer = 0.
- FSM states: IDLE, CLEAR.
- IDLE, clr=1 at edge:
  - Next state CLEAR, pointer = 0, busy = 1 from that edge.
  - If we=1 on the same edge: clr has priority; the write is dropped and wr_err = 1 for one cycle.
- IDLE, clr=0, we=1 at edge (accepted write):
  - For each i with be[i]=1, byte i of to_reg[wAddr] takes wData byte i; other bytes hold.
  - wr_ack = 1 for exactly the following cycle.
  - dirty[wAddr] set if be != 0.
  - be = 0: no data change, dirty unchanged, wr_ack still pulses.
  - Latency: written value visible on to_regN one edge after the request; the read stage sees it combinationally from then on.
- IDLE, we=0, clr=0: all registers and the dirty bitmap hold; wr_ack = wr_err = 0.
- CLEAR, each edge:
  - to_reg[pointer] = 0, dirty[pointer] = 0, pointer increments.
  - After the edge that clears register 7: state = IDLE, busy = 0, pointer wraps to 0.
  - The sweep takes exactly 8 edges with busy high.
  - busy falls on the edge that clears register 7; a write presented on the next edge is accepted.
- CLEAR, we=1: the write is dropped, wr_err = 1 for the following cycle, no register or dirty change.
- clr held high continuously: a new sweep starts from the first IDLE edge where it is sampled (back-to-back sweeps with one IDLE cycle between them).
- Registers not yet reached by the sweep keep their values until swept; each register is independent and no other outputs are touched.
- wr_ack and wr_err are mutually exclusive and never high on the same cycle.

Test Plan:
- Reset then per-address writes: release reset_n; write wData = 32'h0000000f, 32'h000000ff, 32'h00000fff, 32'h0000ffff, 32'h000f0000, 32'h00ff0000, 32'h0fff0000, 32'hffff0000 to addresses 0..7 with be = 4'hf -> each to_regN equals its value one edge after its request, wr_ack pulses 8 times, dirty = 8'hff.
- Byte enables: to_reg3 = 32'h0000ffff, write 32'hAABBCCDD with be = 4'b1010 -> to_reg3 = 32'hAA00CC00... byte-merged as 32'hAA00CCff? Required result: bytes 3 and 1 replaced, bytes 2 and 0 held -> 32'hAA00CCff. A write with be = 4'b0000 -> value unchanged, wr_ack = 1, dirty unchanged.
- Clear sweep: all registers non-zero, pulse clr -> busy high for exactly 8 cycles; to_reg0..7 zero in order, one per cycle; dirty bits clear in order to 8'h00; busy = 0 afterwards.
- Write during sweep and simultaneous request: we=1 to addr 5 during cycle 3 of the sweep -> wr_err pulse, to_reg5 ends 0. In IDLE, we=1 and clr=1 on the same edge -> wr_err = 1, sweep starts, no write.
- Asynchronous reset mid-sweep: assert reset_n=0 between clock edges at sweep cycle 4 -> all outputs 0 immediately without waiting for an edge; after release, state IDLE, busy = 0, and a new write is accepted on the first edge.
- Post-sweep write: write to addr 7 on the first edge after busy falls -> accepted, wr_ack = 1, dirty = 8'h80.
